// File: rtl/bp_dma_mover.sv
// rtl/bp_dma_mover.sv - DMA transfer sequencer issuing BedRock uncached 8B read/write streams
module bp_dma_mover #(
  parameter int paddr_width_p  = 40,
  parameter int lce_id_width_p = 8,
  parameter int addr_width_p   = 32,
  parameter int stride_width_p = 32,
  parameter int count_width_p  = 32,
  parameter int buf_els_p      = 4,
  localparam int mem_fwd_header_width_lp = lce_id_width_p + 3 + paddr_width_p + 8,
  localparam int mem_rev_header_width_lp = mem_fwd_header_width_lp
) (
  input  logic                               clk_i,
  input  logic                               reset_n_i,
  input  logic                               start_i,
  input  logic [addr_width_p-1:0]            rd_base_addr_i,
  input  logic [stride_width_p-1:0]          rd_stride_i,
  input  logic [addr_width_p-1:0]            wr_base_addr_i,
  input  logic [stride_width_p-1:0]          wr_stride_i,
  input  logic [count_width_p-1:0]           count_i,
  input  logic [lce_id_width_p-1:0]          lce_id_i,
  output logic                               busy_o,
  output logic                               done_o,
  output logic                               err_o,
  output logic [mem_fwd_header_width_lp-1:0] mem_fwd_header_o,
  output logic [63:0]                        mem_fwd_data_o,
  output logic                               mem_fwd_v_o,
  input  logic                               mem_fwd_ready_and_i,
  output logic                               mem_fwd_last_o,
  input  logic [mem_rev_header_width_lp-1:0] mem_rev_header_i,
  input  logic [63:0]                        mem_rev_data_i,
  input  logic                               mem_rev_v_i,
  output logic                               mem_rev_ready_and_o,
  input  logic                               mem_rev_last_i
);

  localparam int ptr_w_lp = (buf_els_p > 1) ? $clog2(buf_els_p) : 1;
  localparam int occ_w_lp = $clog2(buf_els_p + 1);

  localparam logic [3:0] e_bedrock_mem_uc_rd  = 4'd2;
  localparam logic [3:0] e_bedrock_mem_uc_wr  = 4'd3;
  localparam logic [2:0] e_bedrock_msg_size_8 = 3'd3;

  // Header layout: payload (lce_id) in the MSBs, msg_type in the LSBs
  typedef struct packed {
    logic [lce_id_width_p-1:0] lce_id;
    logic [2:0]                size;
    logic [paddr_width_p-1:0]  addr;
    logic [3:0]                subop;
    logic [3:0]                msg_type;
  } bp_bedrock_mem_header_s;

  typedef enum logic [1:0] {e_idle, e_run, e_drain, e_done} state_e;

  state_e                     state_q, state_d;
  logic                       busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic                       fwd_v_q, fwd_v_d;
  bp_bedrock_mem_header_s     fwd_hdr_q, fwd_hdr_d;
  logic [63:0]                fwd_data_q, fwd_data_d;
  logic [paddr_width_p-1:0]   rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
  logic [paddr_width_p-1:0]   rd_stride_q, rd_stride_d, wr_stride_q, wr_stride_d;
  logic [count_width_p-1:0]   count_q, count_d, rd_idx_q, rd_idx_d;
  logic [count_width_p-1:0]   wr_idx_q, wr_idx_d, wr_ack_q, wr_ack_d;
  logic [lce_id_width_p-1:0]  lce_id_q, lce_id_d;
  logic [occ_w_lp-1:0]        inflight_q, inflight_d, occ_q, occ_d;
  logic [ptr_w_lp-1:0]        rptr_q, rptr_d, wptr_q, wptr_d;
  logic [63:0]                buf_mem_q [buf_els_p];

  bp_bedrock_mem_header_s     rev_hdr;
  logic                       xfer_active, fwd_hs, rd_hs, wr_hs, push, pop, err_set;
  logic                       unused_rev;

  assign rev_hdr    = mem_rev_header_i;
  assign unused_rev = ^{rev_hdr.lce_id, rev_hdr.size, rev_hdr.addr, rev_hdr.subop, mem_rev_last_i};

  assign busy_o              = busy_q;
  assign done_o              = done_q;
  assign err_o               = err_q;
  assign mem_fwd_v_o         = fwd_v_q;
  assign mem_fwd_header_o    = fwd_hdr_q;
  assign mem_fwd_data_o      = fwd_data_q;
  assign mem_fwd_last_o      = 1'b1;
  assign mem_rev_ready_and_o = 1'b1;

  function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
    return (p == ptr_w_lp'(buf_els_p - 1)) ? '0 : p + ptr_w_lp'(1);
  endfunction

  // Next-state, command issue and response bookkeeping for the whole sequencer
  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = done_q;
    err_d       = err_q;
    fwd_v_d     = fwd_v_q;
    fwd_hdr_d   = fwd_hdr_q;
    fwd_data_d  = fwd_data_q;
    rd_addr_d   = rd_addr_q;
    wr_addr_d   = wr_addr_q;
    rd_stride_d = rd_stride_q;
    wr_stride_d = wr_stride_q;
    count_d     = count_q;
    rd_idx_d    = rd_idx_q;
    wr_idx_d    = wr_idx_q;
    wr_ack_d    = wr_ack_q;
    lce_id_d    = lce_id_q;
    inflight_d  = inflight_q;
    occ_d       = occ_q;
    rptr_d      = rptr_q;
    wptr_d      = wptr_q;
    err_set     = 1'b0;
    push        = 1'b0;

    xfer_active = (state_q == e_run) || (state_q == e_drain);
    fwd_hs      = fwd_v_q & mem_fwd_ready_and_i;
    rd_hs       = fwd_hs & (fwd_hdr_q.msg_type == e_bedrock_mem_uc_rd);
    wr_hs       = fwd_hs & (fwd_hdr_q.msg_type == e_bedrock_mem_uc_wr);
    pop         = wr_hs;

    // A read response is only legal if a read is actually in flight, which
    // also guarantees the buffer slot reserved at issue time is still free.
    if (mem_rev_v_i) begin
      if (xfer_active && rev_hdr.msg_type == e_bedrock_mem_uc_rd && inflight_q != '0) begin
        push = 1'b1;
      end else if (xfer_active && rev_hdr.msg_type == e_bedrock_mem_uc_wr && wr_ack_q < count_q) begin
        wr_ack_d = wr_ack_q + count_width_p'(1);
      end else begin
        err_set = 1'b1;
      end
    end

    inflight_d = inflight_q + occ_w_lp'(rd_hs) - occ_w_lp'(push);
    occ_d      = occ_q + occ_w_lp'(push) - occ_w_lp'(pop);
    if (push) wptr_d = ptr_inc(wptr_q);
    if (pop)  rptr_d = ptr_inc(rptr_q);

    // Addresses advance as running sums so no multiplier is needed
    if (rd_hs) begin
      rd_idx_d  = rd_idx_q + count_width_p'(1);
      rd_addr_d = rd_addr_q + rd_stride_q;
    end
    if (wr_hs) begin
      wr_idx_d  = wr_idx_q + count_width_p'(1);
      wr_addr_d = wr_addr_q + wr_stride_q;
    end
    if (fwd_hs) fwd_v_d = 1'b0;

    case (state_q)
      e_idle: begin
        if (start_i) begin
          rd_addr_d   = paddr_width_p'(rd_base_addr_i);
          wr_addr_d   = paddr_width_p'(wr_base_addr_i);
          rd_stride_d = paddr_width_p'(signed'(rd_stride_i));
          wr_stride_d = paddr_width_p'(signed'(wr_stride_i));
          count_d     = count_i;
          lce_id_d    = lce_id_i;
          rd_idx_d    = '0;
          wr_idx_d    = '0;
          wr_ack_d    = '0;
          inflight_d  = '0;
          occ_d       = '0;
          rptr_d      = '0;
          wptr_d      = '0;
          err_d       = 1'b0;
          state_d     = (count_i == '0) ? e_done : e_run;
        end
      end
      e_run: begin
        // New commands are only chosen while the output slot is empty, so the
        // presented header and data never change under back-pressure.
        if (!fwd_v_q) begin
          if (occ_q != '0 && wr_idx_q < count_q) begin
            fwd_v_d            = 1'b1;
            fwd_hdr_d          = '0;
            fwd_hdr_d.msg_type = e_bedrock_mem_uc_wr;
            fwd_hdr_d.size     = e_bedrock_msg_size_8;
            fwd_hdr_d.addr     = wr_addr_q;
            fwd_hdr_d.lce_id   = lce_id_q;
            fwd_data_d         = buf_mem_q[rptr_q];
          end else if (rd_idx_q < count_q && (int'(inflight_q) + int'(occ_q)) < buf_els_p) begin
            fwd_v_d            = 1'b1;
            fwd_hdr_d          = '0;
            fwd_hdr_d.msg_type = e_bedrock_mem_uc_rd;
            fwd_hdr_d.size     = e_bedrock_msg_size_8;
            fwd_hdr_d.addr     = rd_addr_q;
            fwd_hdr_d.lce_id   = lce_id_q;
            fwd_data_d         = '0;
          end
        end
        if (wr_idx_d == count_q) state_d = e_drain;
      end
      e_drain: begin
        if (wr_ack_q == count_q) state_d = e_done;
      end
      default: begin
        state_d = e_idle;
      end
    endcase

    if (err_set) err_d = 1'b1;
    busy_d = (state_d == e_run) || (state_d == e_drain);
    done_d = (state_d == e_done);
  end

  // Single register stage for FSM, counters and registered outputs
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= e_idle;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      fwd_v_q     <= 1'b0;
      fwd_hdr_q   <= '0;
      fwd_data_q  <= '0;
      rd_addr_q   <= '0;
      wr_addr_q   <= '0;
      rd_stride_q <= '0;
      wr_stride_q <= '0;
      count_q     <= '0;
      rd_idx_q    <= '0;
      wr_idx_q    <= '0;
      wr_ack_q    <= '0;
      lce_id_q    <= '0;
      inflight_q  <= '0;
      occ_q       <= '0;
      rptr_q      <= '0;
      wptr_q      <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      fwd_v_q     <= fwd_v_d;
      fwd_hdr_q   <= fwd_hdr_d;
      fwd_data_q  <= fwd_data_d;
      rd_addr_q   <= rd_addr_d;
      wr_addr_q   <= wr_addr_d;
      rd_stride_q <= rd_stride_d;
      wr_stride_q <= wr_stride_d;
      count_q     <= count_d;
      rd_idx_q    <= rd_idx_d;
      wr_idx_q    <= wr_idx_d;
      wr_ack_q    <= wr_ack_d;
      lce_id_q    <= lce_id_d;
      inflight_q  <= inflight_d;
      occ_q       <= occ_d;
      rptr_q      <= rptr_d;
      wptr_q      <= wptr_d;
    end
  end

  // Read-data buffer storage; contents are don't-care while empty
  always_ff @(posedge clk_i) begin
    if (push) buf_mem_q[wptr_q] <= mem_rev_data_i;
  end

endmodule

// File: tb/tb_bp_dma_mover.sv
// tb/tb_bp_dma_mover.sv - self-checking bench for bp_dma_mover
module tb_bp_dma_mover;
  localparam int PW  = 40;
  localparam int LW  = 8;
  localparam int HW  = LW + 3 + PW + 8;
  localparam int BUF = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [31:0]   rd_base = '0, rd_stride = '0, wr_base = '0, wr_stride = '0, count = '0;
  logic [LW-1:0] lce = '0;
  logic          busy, done, err;
  logic [HW-1:0] fwd_hdr;
  logic [63:0]   fwd_data;
  logic          fwd_v, fwd_last;
  logic          fwd_ready = 1'b1;
  logic [HW-1:0] rev_hdr = '0;
  logic [63:0]   rev_data = '0;
  logic          rev_v = 1'b0;
  logic          rev_ready;
  logic          rev_last = 1'b1;

  always #5 clk = ~clk;

  bp_dma_mover dut (
    .clk_i(clk), .reset_n_i(reset_n), .start_i(start),
    .rd_base_addr_i(rd_base), .rd_stride_i(rd_stride),
    .wr_base_addr_i(wr_base), .wr_stride_i(wr_stride),
    .count_i(count), .lce_id_i(lce),
    .busy_o(busy), .done_o(done), .err_o(err),
    .mem_fwd_header_o(fwd_hdr), .mem_fwd_data_o(fwd_data), .mem_fwd_v_o(fwd_v),
    .mem_fwd_ready_and_i(fwd_ready), .mem_fwd_last_o(fwd_last),
    .mem_rev_header_i(rev_hdr), .mem_rev_data_i(rev_data), .mem_rev_v_i(rev_v),
    .mem_rev_ready_and_o(rev_ready), .mem_rev_last_i(rev_last)
  );

  logic [63:0]   mem_model [logic [PW-1:0]];
  logic [PW-1:0] rd_log[$];
  logic [PW-1:0] wr_log[$];
  logic [63:0]   wd_log[$];
  logic [3:0]    rq_type[$];
  logic [63:0]   rq_data[$];
  bit            hold_rev = 1'b0, rdy_rand = 1'b0, inj_pending = 1'b0, prev_stall = 1'b0;
  logic [HW-1:0] inj_hdr = '0, prev_hdr = '0;
  logic [63:0]   prev_data = '0;
  logic [PW-1:0] resp_addr;
  logic [LW-1:0] cur_lce = '0;
  int            out_cnt = 0, max_out = 0;
  int            checks = 0, errors = 0, done_cnt = 0, fwd_v_cnt = 0;

  function automatic logic [PW-1:0] exp_addr(input logic [31:0] base, input logic [31:0] stride, input int i);
    return PW'(base) + PW'(i) * PW'(signed'(stride));
  endfunction

  // Memory responder: in-order, random or full command acceptance, optional hold-off
  always @(negedge clk) begin
    if (!reset_n) begin
      rq_type.delete(); rq_data.delete();
      rev_v = 1'b0; fwd_ready = 1'b1; out_cnt = 0; prev_stall = 1'b0;
    end else begin
      rev_v = 1'b0; rev_hdr = '0; rev_data = '0;
      if (inj_pending) begin
        rev_v = 1'b1; rev_hdr = inj_hdr; inj_pending = 1'b0;
      end else if (!hold_rev && rq_type.size() > 0) begin
        rev_v = 1'b1;
        rev_hdr[3:0] = rq_type.pop_front();
        rev_data = rq_data.pop_front();
        if (rev_hdr[3:0] == 4'd2) out_cnt--;
      end
      fwd_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (prev_stall) begin
        checks++;
        if (fwd_v !== 1'b1 || fwd_hdr !== prev_hdr || fwd_data !== prev_data) begin
          errors++;
          $display("FAIL fwd_hold: got v=%b hdr=%h data=%h, required v=1 hdr=%h data=%h",
                   fwd_v, fwd_hdr, fwd_data, prev_hdr, prev_data);
        end
      end
      if (fwd_v === 1'b1 && fwd_ready) begin
        checks++;
        if (fwd_hdr[7:4] !== 4'd0 || fwd_hdr[50:48] !== 3'd3 || fwd_hdr[58:51] !== cur_lce) begin
          errors++;
          $display("FAIL hdr_fields: got subop=%h size=%h lce=%h, required subop=0 size=3 lce=%h",
                   fwd_hdr[7:4], fwd_hdr[50:48], fwd_hdr[58:51], cur_lce);
        end
        resp_addr = fwd_hdr[47:8];
        if (fwd_hdr[3:0] == 4'd2) begin
          if (!mem_model.exists(resp_addr)) mem_model[resp_addr] = {$urandom, $urandom};
          rd_log.push_back(resp_addr);
          rq_type.push_back(4'd2); rq_data.push_back(mem_model[resp_addr]);
          out_cnt++;
          if (out_cnt > max_out) max_out = out_cnt;
        end else if (fwd_hdr[3:0] == 4'd3) begin
          wr_log.push_back(resp_addr); wd_log.push_back(fwd_data);
          rq_type.push_back(4'd3); rq_data.push_back(64'd0);
        end else begin
          checks++; errors++;
          $display("FAIL msg_type: got %h, required 2 or 3", fwd_hdr[3:0]);
        end
      end
      prev_stall = (fwd_v === 1'b1) && !fwd_ready;
      prev_hdr   = fwd_hdr;
      prev_data  = fwd_data;
    end
  end

  // Pulse/valid monitor sampled just after each rising edge
  always @(posedge clk) begin
    #1;
    if (done === 1'b1) done_cnt++;
    if (fwd_v === 1'b1) fwd_v_cnt++;
  end

  task automatic do_xfer(input int n, input logic [31:0] rb, input logic [31:0] rs,
                         input logic [31:0] wb, input logic [31:0] ws,
                         input bit rnd, input int hold, input string nm);
    int d0, cyc;
    logic [PW-1:0] ea;
    rd_log.delete(); wr_log.delete(); wd_log.delete(); max_out = 0;
    rdy_rand = rnd; cur_lce = LW'($urandom);
    @(negedge clk);
    rd_base = rb; rd_stride = rs; wr_base = wb; wr_stride = ws; count = 32'(n);
    lce = cur_lce; hold_rev = (hold > 0); start = 1'b1;
    d0 = done_cnt;
    @(negedge clk); start = 1'b0; #1;
    checks++;
    if (n == 0 && done !== 1'b1) begin errors++; $display("FAIL %s done_next: got %b required 1", nm, done); end
    else if (n != 0 && busy !== 1'b1) begin errors++; $display("FAIL %s busy_start: got %b required 1", nm, busy); end
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      #1;
      checks++;
      if (out_cnt != BUF || rd_log.size() != BUF || max_out != BUF) begin
        errors++;
        $display("FAIL %s outstanding: got out=%0d reads=%0d max=%0d required %0d", nm, out_cnt, rd_log.size(), max_out, BUF);
      end
      hold_rev = 1'b0;
    end
    cyc = 0;
    while (done_cnt == d0 && cyc < 3000) begin @(negedge clk); cyc++; end
    checks++;
    if (cyc >= 3000) begin errors++; $display("FAIL %s timeout: no done_o after %0d cycles", nm, cyc); end
    @(negedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL %s after_done: got done=%b busy=%b required 0 0", nm, done, busy);
    end
    @(negedge clk); #1;
    checks++;
    if (done_cnt != d0 + 1) begin errors++; $display("FAIL %s done_pulses: got %0d required 1", nm, done_cnt - d0); end
    checks++;
    if (rd_log.size() != n || wr_log.size() != n) begin
      errors++; $display("FAIL %s n_cmds: got rd=%0d wr=%0d required %0d", nm, rd_log.size(), wr_log.size(), n);
    end
    if (max_out > BUF) begin
      checks++; errors++; $display("FAIL %s max_out: got %0d required <= %0d", nm, max_out, BUF);
    end
    for (int i = 0; i < n && i < rd_log.size(); i++) begin
      ea = exp_addr(rb, rs, i);
      checks++;
      if (rd_log[i] !== ea) begin errors++; $display("FAIL %s rd_addr[%0d]: got %h required %h", nm, i, rd_log[i], ea); end
    end
    for (int i = 0; i < n && i < wr_log.size(); i++) begin
      ea = exp_addr(wb, ws, i);
      checks++;
      if (wr_log[i] !== ea) begin errors++; $display("FAIL %s wr_addr[%0d]: got %h required %h", nm, i, wr_log[i], ea); end
      checks++;
      if (wd_log[i] !== mem_model[exp_addr(rb, rs, i)]) begin
        errors++; $display("FAIL %s wr_data[%0d]: got %h required %h", nm, i, wd_log[i], mem_model[exp_addr(rb, rs, i)]);
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b required 0", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b required 0", err); end
    checks++; if (fwd_v !== 1'b0) begin errors++; $display("FAIL reset_fwd_v: got %b required 0", fwd_v); end
    checks++; if (fwd_last !== 1'b1) begin errors++; $display("FAIL reset_fwd_last: got %b required 1", fwd_last); end
    checks++; if (rev_ready !== 1'b1) begin errors++; $display("FAIL reset_rev_ready: got %b required 1", rev_ready); end
    @(negedge clk); reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_count_zero();
    int v0;
    v0 = fwd_v_cnt;
    do_xfer(0, 32'h1000, 32'd8, 32'h2000, 32'd8, 1'b0, 0, "count0");
    checks++;
    if (fwd_v_cnt != v0) begin errors++; $display("FAIL count0_no_fwd: got %0d valid cycles required 0", fwd_v_cnt - v0); end
  endtask

  task automatic test_single();
    mem_model[40'h1000] = 64'hDEADBEEF;
    do_xfer(1, 32'h1000, 32'd8, 32'h2000, 32'd8, 1'b0, 0, "single");
    if (wd_log.size() > 0) begin
      checks++;
      if (wr_log[0] !== 40'h2000 || wd_log[0] !== 64'hDEADBEEF) begin
        errors++; $display("FAIL single_wr: got addr=%h data=%h required 2000 deadbeef", wr_log[0], wd_log[0]);
      end
    end
  endtask

  task automatic test_strides();
    do_xfer(8, 32'h1000, 32'd8, 32'h2000, 32'd16, 1'b0, 0, "stride");
    if (rd_log.size() == 8 && wr_log.size() == 8) begin
      checks++;
      if (rd_log[7] !== 40'h1038 || wr_log[7] !== 40'h2070) begin
        errors++; $display("FAIL stride_last: got rd=%h wr=%h required 1038 2070", rd_log[7], wr_log[7]);
      end
    end
  endtask

  task automatic test_holdoff();
    do_xfer(8, 32'h3000, 32'd8, 32'h4000, 32'd8, 1'b0, 20, "holdoff");
  endtask

  task automatic test_backpressure();
    int s1, s2;
    for (int k = 0; k < 3; k++) begin
      s1 = (int'($urandom_range(0, 16)) - 8) * 8;
      s2 = (int'($urandom_range(0, 16)) - 8) * 8;
      do_xfer(int'($urandom_range(5, 20)), {$urandom_range(0, 65535), 3'b000} , 32'(s1),
              {$urandom_range(0, 65535), 3'b000}, 32'(s2), 1'b1, 0, "backpressure");
    end
  endtask

  task automatic test_wrap();
    do_xfer(4, 32'h10, -32'sd8, 32'h0, -32'sd16, 1'b1, 0, "wrap");
    if (rd_log.size() == 4 && wr_log.size() == 4) begin
      checks++;
      if (rd_log[3] !== 40'hFF_FFFF_FFF8 || wr_log[1] !== 40'hFF_FFFF_FFF0) begin
        errors++; $display("FAIL wrap_addr: got rd3=%h wr1=%h required fffffffff8 fffffffff0", rd_log[3], wr_log[1]);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 4; k++) begin
      do_xfer(int'($urandom_range(1, 12)), $urandom & 32'hFFFF_FFF8, 32'($urandom_range(0, 8) * 8),
              $urandom & 32'hFFFF_FFF8, 32'($urandom_range(0, 8) * 8), 1'($urandom_range(0, 1)), 0, "random");
    end
  endtask

  task automatic test_err();
    @(negedge clk);
    inj_hdr = '0; inj_hdr[3:0] = 4'd2; inj_pending = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_idle_rev: got %b required 1", err); end
    repeat (4) @(negedge clk);
    #1;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b required 1", err); end
    do_xfer(2, 32'h5000, 32'd8, 32'h6000, 32'd8, 1'b0, 0, "err_clear");
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_cleared: got %b required 0", err); end
  endtask

  task automatic test_reset_mid_run();
    int d0, v0;
    rdy_rand = 1'b1; hold_rev = 1'b0;
    @(negedge clk);
    rd_base = 32'h7000; rd_stride = 32'd8; wr_base = 32'h8000; wr_stride = 32'd8; count = 32'd16; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (15) @(negedge clk);
    reset_n = 1'b0;
    d0 = done_cnt;
    #1;
    checks++;
    if (busy !== 1'b0 || fwd_v !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL mid_reset: got busy=%b v=%b done=%b err=%b required 0 0 0 0", busy, fwd_v, done, err);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    v0 = fwd_v_cnt;
    repeat (20) @(negedge clk);
    #1;
    checks++;
    if (done_cnt != d0 || fwd_v_cnt != v0 || busy !== 1'b0) begin
      errors++; $display("FAIL mid_reset_idle: got done_pulses=%0d v_cycles=%0d busy=%b required 0 0 0",
                         done_cnt - d0, fwd_v_cnt - v0, busy);
    end
    do_xfer(3, 32'h9000, 32'd8, 32'hA000, 32'd8, 1'b0, 0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_count_zero();
    test_single();
    test_strides();
    test_holdoff();
    test_backpressure();
    test_wrap();
    test_random();
    test_err();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
